// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
package quad_decoder_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Mod-4 phase differences between successive samples.
    localparam phase_t PH_UP  = 2'd1;
    localparam phase_t PH_DN  = 2'd3;
    localparam phase_t PH_ILL = 2'd2;

    // Gray-coded {A,B} to phase index: 00->0, 01->1, 11->2, 10->3.
    function automatic phase_t ab_to_phase(input logic a, input logic b);
        phase_t ph;
        case ({a, b})
            2'b00:   ph = 2'd0;
            2'b01:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Glitch filter for one synchronized encoder phase: the output follows the
// input only after FILTER_LEN consecutive samples that differ from it.
module quad_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] RELOAD = 4'(FILTER_LEN - 1);

    logic       dout_q, dout_d;
    logic [3:0] cnt_q, cnt_d;

    // Down-count while the input disagrees with the output; flip at terminal count.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (din == dout_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == 4'd0) begin
            dout_d = din;
            cnt_d  = RELOAD;
        end else begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= 1'b0;
            cnt_q  <= RELOAD;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder with loadable position counter and sticky error flag.
// Optional glitch filter on each phase enabled by QUAD_DEC_FILTER_EN.
//
// state | meaning
// INIT  | waiting for the input pipeline to settle, then capture the phase
// RUN   | decoding transitions against the previous phase
module quad_decoder #(
    parameter int SIZE       = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            quad_a,
    input  logic            quad_b,
    input  logic            load,
    input  logic [SIZE-1:0] data,
    input  logic            err_clr,
    output logic [SIZE-1:0] out,
    output logic            step,
    output logic            up_dwn,
    output logic            err
);

    import quad_decoder_pkg::*;

    // A bad override is reported even when the filter is compiled out.
    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("quad_decoder: FILTER_LEN must be in 2..15");
    end

    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       a_f, b_f;

    // Two-flop synchronizer for both phases.
    always_comb begin
        sync1_d = {quad_a, quad_b};
        sync2_d = sync1_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Cycles after reset before the decoder's input reflects the pins:
    // the synchronizer depth, plus the filter length when present.
`ifdef QUAD_DEC_FILTER_EN
    localparam logic [4:0] SETTLE = 5'(2 + FILTER_LEN);

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .din   (sync2_q[1]),
        .dout  (a_f)
    );

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .din   (sync2_q[0]),
        .dout  (b_f)
    );
`else
    localparam logic [4:0] SETTLE = 5'd2;

    assign a_f = sync2_q[1];
    assign b_f = sync2_q[0];
`endif

    state_t          state_q, state_d;
    logic [4:0]      settle_q, settle_d;
    phase_t          prev_q, prev_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            step_q, step_d;
    logic            up_q, up_d;
    logic            err_q, err_d;
    phase_t          cur_ph, delta;

    // Decode the phase change and compute the next count, step, direction and error.
    always_comb begin
        cur_ph   = ab_to_phase(a_f, b_f);
        delta    = cur_ph - prev_q;
        state_d  = state_q;
        settle_d = settle_q;
        prev_d   = prev_q;
        out_d    = out_q;
        step_d   = 1'b0;
        up_d     = up_q;
        err_d    = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            INIT: begin
                if (settle_q == 5'd0) begin
                    prev_d  = cur_ph;
                    state_d = RUN;
                end else begin
                    settle_d = settle_q - 5'd1;
                end
            end
            RUN: begin
                prev_d = cur_ph;
                case (delta)
                    PH_UP: begin
                        step_d = 1'b1;
                        up_d   = 1'b1;
                        out_d  = out_q + 1'b1;
                    end
                    PH_DN: begin
                        step_d = 1'b1;
                        up_d   = 1'b0;
                        out_d  = out_q - 1'b1;
                    end
                    PH_ILL: begin
                        err_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = INIT;
        endcase

        if (load) begin
            out_d = data;
        end
    end

    // Decoder and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT;
            settle_q <= SETTLE;
            prev_q   <= 2'd0;
            out_q    <= '0;
            step_q   <= 1'b0;
            up_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            prev_q   <= prev_d;
            out_q    <= out_d;
            step_q   <= step_d;
            up_q     <= up_d;
            err_q    <= err_d;
        end
    end

    assign out    = out_q;
    assign step   = step_q;
    assign up_dwn = up_q;
    assign err    = err_q;

endmodule
